sdram_ring_handler: RTL and testbench

SDRAM_RING_HANDLER -- requirements
Module: sdram_ring_handler

---
 rtl/sdram_ring_handler.sv | 141 ++++++++++++++
 tb/tb_sdram_ring_handler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_ring_handler.sv
// sdram_ring_handler: moves write-FIFO words into an SDRAM ring buffer and issues
// counted reads from it, arbitrating both onto one controller command channel.
module sdram_ring_handler #(
  parameter int AW = 24,
  parameter int DW = 16,
  parameter int CW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          w_en,
  input  logic [DW-1:0] w_data,
  input  logic          w_empty,
  output logic          r_en,
  output logic [DW-1:0] r_data,
  input  logic          r_almost_full,
  input  logic          rprio,
  output logic          c_avalid,
  input  logic          c_aready,
  output logic          c_awe,
  output logic [AW-1:0] c_aaddr,
  output logic [DW-1:0] c_adata,
  input  logic          c_bvalid,
  input  logic          c_bwe,
  input  logic [DW-1:0] c_bdata,
  input  logic          avalid,
  input  logic          awe,
  input  logic [2:0]    aaddr,
  input  logic [31:0]   adata,
  output logic          bvalid,
  output logic [31:0]   bdata
);
  logic [AW-1:0] raddr_q, raddr_d, waddr_q, waddr_d, base_q, base_d, limit_q, limit_d;
  logic [CW-1:0] rcount_q, rcount_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic [15:0]   wraps_q, wraps_d;
  logic          ovf_q, ovf_d, wfull_q, wfull_d, last_wr_q, last_wr_d;
  logic          lock_q, lock_d, sel_wr_q, sel_wr_d;
  logic [7:0]    outst_q, outst_d;
  logic          bvalid_q, bvalid_d;
  logic [31:0]   bdata_q, bdata_d, rd_mux;
  logic          en, ring, w_able, r_able, pick_wr, acc, wr_acc, rd_acc;
  logic          hw, base_wr, st_clr, w_lim, r_lim;
  logic [1:0]    mode;

  always_comb begin
    en       = ctrl_q[0];
    ring     = ctrl_q[1];
    mode     = ctrl_q[3:2];
    w_able   = en && !w_empty && !wfull_q;
    r_able   = en && rcount_q != '0 && !r_almost_full;
    pick_wr  = w_able && (!r_able || mode == 2'd0 || (mode == 2'd2 && !last_wr_q) ||
                          (mode == 2'd3 && !rprio));
    // A presented but unaccepted command keeps its side while that side stays able
    sel_wr_d = (lock_q && (sel_wr_q ? w_able : r_able)) ? sel_wr_q : pick_wr;
    c_avalid = w_able || r_able;
    c_awe    = sel_wr_d;
    c_aaddr  = sel_wr_d ? waddr_q : raddr_q;
    c_adata  = w_data;
    acc      = c_avalid && c_aready;
    wr_acc   = acc && sel_wr_d;
    rd_acc   = acc && !sel_wr_d;
    w_en     = wr_acc;
    // Only responses to reads issued since reset are forwarded
    r_en     = c_bvalid && !c_bwe && outst_q != '0;
    r_data   = c_bdata;
    lock_d   = c_avalid && !c_aready;
    last_wr_d = acc ? sel_wr_d : last_wr_q;
    outst_d  = outst_q + 8'(rd_acc) - 8'(r_en);
    hw       = avalid && awe;
    base_wr  = hw && aaddr == 3'd2;
    st_clr   = hw && aaddr == 3'd5 && adata[3];
    w_lim    = waddr_q == limit_q;
    r_lim    = raddr_q == limit_q;
    raddr_d  = (hw && aaddr == 3'd0) ? adata[AW-1:0] :
               rd_acc ? (r_lim ? (ring ? base_q : raddr_q) : raddr_q + AW'(1)) : raddr_q;
    rcount_d = (hw && aaddr == 3'd1) ? adata[CW-1:0] : rd_acc ? rcount_q - CW'(1) : rcount_q;
    base_d   = base_wr ? adata[AW-1:0] : base_q;
    limit_d  = (hw && aaddr == 3'd3) ? adata[AW-1:0] : limit_q;
    ctrl_d   = (hw && aaddr == 3'd4) ? adata[3:0] : ctrl_q;
    waddr_d  = (base_wr || (hw && aaddr == 3'd6)) ? adata[AW-1:0] :
               wr_acc ? (w_lim ? (ring ? base_q : waddr_q) : waddr_q + AW'(1)) : waddr_q;
    wraps_d  = base_wr ? 16'd0 : (hw && aaddr == 3'd7) ? adata[15:0] :
               (wr_acc && w_lim && ring) ? wraps_q + 16'd1 : wraps_q;
    wfull_d  = !(st_clr || base_wr) && (wfull_q || (wr_acc && w_lim && !ring));
    ovf_d    = !st_clr && (ovf_q || (wfull_q && !w_empty && en));
    bvalid_d = avalid;
    bdata_d  = (avalid && !awe) ? rd_mux : 32'd0;
  end

  always_comb begin
    case (aaddr)
      3'd0:    rd_mux = 32'(raddr_q);
      3'd1:    rd_mux = 32'(rcount_q);
      3'd2:    rd_mux = 32'(base_q);
      3'd3:    rd_mux = 32'(limit_q);
      3'd4:    rd_mux = {28'd0, ctrl_q};
      3'd5:    rd_mux = {28'd0, ovf_q, wfull_q, rcount_q != '0, en};
      3'd6:    rd_mux = 32'(waddr_q);
      default: rd_mux = {16'd0, wraps_q};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q   <= '0;
      rcount_q  <= '0;
      base_q    <= '0;
      limit_q   <= '1;
      ctrl_q    <= '0;
      waddr_q   <= '0;
      wraps_q   <= '0;
      ovf_q     <= 1'b0;
      wfull_q   <= 1'b0;
      last_wr_q <= 1'b0;
      lock_q    <= 1'b0;
      sel_wr_q  <= 1'b0;
      outst_q   <= '0;
      bvalid_q  <= 1'b0;
      bdata_q   <= '0;
    end else begin
      raddr_q   <= raddr_d;
      rcount_q  <= rcount_d;
      base_q    <= base_d;
      limit_q   <= limit_d;
      ctrl_q    <= ctrl_d;
      waddr_q   <= waddr_d;
      wraps_q   <= wraps_d;
      ovf_q     <= ovf_d;
      wfull_q   <= wfull_d;
      last_wr_q <= last_wr_d;
      lock_q    <= lock_d;
      sel_wr_q  <= sel_wr_d;
      outst_q   <= outst_d;
      bvalid_q  <= bvalid_d;
      bdata_q   <= bdata_d;
    end
  end

  assign bvalid = bvalid_q;
  assign bdata  = bdata_q;
endmodule

// File: tb/tb_sdram_ring_handler.sv
// tb_sdram_ring_handler: directed self-checking bench for sdram_ring_handler.
module tb_sdram_ring_handler;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        w_en, w_empty = 1'b1, r_en, r_almost_full = 1'b0, rprio = 1'b0;
  logic [15:0] w_data = '0, r_data, c_adata, c_bdata = '0;
  logic        c_avalid, c_aready = 1'b0, c_awe, c_bvalid = 1'b0, c_bwe = 1'b0;
  logic [23:0] c_aaddr;
  logic        avalid = 1'b0, awe = 1'b0, bvalid;
  logic [2:0]  aaddr = '0;
  logic [31:0] adata = '0, bdata, rd;
  int checks = 0, errors = 0;

  sdram_ring_handler dut (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_data(w_data), .w_empty(w_empty),
    .r_en(r_en), .r_data(r_data), .r_almost_full(r_almost_full), .rprio(rprio),
    .c_avalid(c_avalid), .c_aready(c_aready), .c_awe(c_awe), .c_aaddr(c_aaddr),
    .c_adata(c_adata), .c_bvalid(c_bvalid), .c_bwe(c_bwe), .c_bdata(c_bdata),
    .avalid(avalid), .awe(awe), .aaddr(aaddr), .adata(adata), .bvalid(bvalid), .bdata(bdata)
  );

  always #5 clk = ~clk;

  task automatic host_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    avalid = 1'b1; awe = 1'b1; aaddr = a; adata = d;
    @(negedge clk);
    avalid = 1'b0; awe = 1'b0;
  endtask

  task automatic host_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    avalid = 1'b1; awe = 1'b0; aaddr = a;
    @(negedge clk);
    avalid = 1'b0;
    d = bdata;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] exp [8];
    exp = '{32'h0, 32'h0, 32'h0, 32'h00FFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    c_bvalid = 1'b1;
    #1;
    checks++;
    if ({c_avalid, w_en, r_en, bvalid} !== 4'b0) begin
      errors++; $display("FAIL reset_outputs got %b exp 0000", {c_avalid, w_en, r_en, bvalid});
    end
    c_bvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_read(3'(i), rd);
      checks++;
      if (rd !== exp[i]) begin errors++; $display("FAIL reset_reg%0d got %h exp %h", i, rd, exp[i]); end
    end
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL read_bvalid got %b exp 1", bvalid); end
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_drop got %b exp 0", bvalid); end
  endtask

  task automatic test_ring_wrap;
    logic [23:0] exp_a [6];
    int pulses = 0;
    exp_a = '{24'h10, 24'h11, 24'h12, 24'h13, 24'h10, 24'h11};
    host_write(3'd2, 32'h10);
    host_write(3'd3, 32'h13);
    host_write(3'd4, 32'h3);
    for (int i = 0; i < 6; i++) begin
      w_empty = 1'b0; c_aready = 1'b1; w_data = 16'hA000 + 16'(i);
      #1;
      checks++;
      if ({c_avalid, c_awe} !== 2'b11 || c_aaddr !== exp_a[i] || c_adata !== w_data) begin
        errors++;
        $display("FAIL ring_cmd%0d got v%b we%b a%h d%h exp v1 we1 a%h d%h",
                 i, c_avalid, c_awe, c_aaddr, c_adata, exp_a[i], w_data);
      end
      pulses += int'(w_en);
      @(negedge clk);
    end
    w_empty = 1'b1; c_aready = 1'b0;
    checks++;
    if (pulses != 6) begin errors++; $display("FAIL ring_wen_pulses got %0d exp 6", pulses); end
    host_read(3'd7, rd);
    checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL ring_wraps got %h exp 1", rd); end
    host_read(3'd6, rd);
    checks++;
    if (rd !== 32'h12) begin errors++; $display("FAIL ring_waddr got %h exp 12", rd); end
  endtask

  task automatic test_linear_full;
    host_write(3'd4, 32'h0);
    host_write(3'd2, 32'h10);
    host_write(3'd4, 32'h1);
    for (int i = 0; i < 6; i++) begin
      w_empty = 1'b0; c_aready = 1'b1;
      #1;
      checks++;
      if (i < 4 && ({c_avalid, w_en} !== 2'b11 || c_aaddr !== 24'h10 + 24'(i))) begin
        errors++; $display("FAIL lin_write%0d got v%b wen%b a%h exp v1 wen1 a%h",
                           i, c_avalid, w_en, c_aaddr, 24'h10 + 24'(i));
      end else if (i >= 4 && {c_avalid, w_en} !== 2'b00) begin
        errors++; $display("FAIL lin_stall%0d got v%b wen%b exp 00", i, c_avalid, w_en);
      end
      @(negedge clk);
    end
    host_read(3'd5, rd);
    checks++;
    if (rd !== 32'hD) begin errors++; $display("FAIL lin_status_full got %h exp d", rd); end
    host_read(3'd6, rd);
    checks++;
    if (rd !== 32'h13) begin errors++; $display("FAIL lin_waddr_hold got %h exp 13", rd); end
    w_empty = 1'b1; c_aready = 1'b0;
    host_write(3'd5, 32'h8);
    host_read(3'd5, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL lin_status_clr got %h exp 1", rd); end
  endtask

  task automatic test_round_robin;
    do_reset();
    host_write(3'd1, 32'd4);
    host_write(3'd0, 32'h20);
    w_empty = 1'b0; c_aready = 1'b1;
    host_write(3'd4, 32'h9);
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (c_avalid !== 1'b1 || c_awe !== (i % 2 == 0) ||
          c_aaddr !== ((i % 2 == 0) ? 24'(i / 2) : 24'h20 + 24'(i / 2))) begin
        errors++; $display("FAIL rr_cycle%0d got v%b we%b a%h", i, c_avalid, c_awe, c_aaddr);
      end
      @(negedge clk);
    end
    w_empty = 1'b1; c_aready = 1'b0;
    host_read(3'd1, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL rr_rcount got %h exp 0", rd); end
    host_read(3'd0, rd);
    checks++;
    if (rd !== 32'h24) begin errors++; $display("FAIL rr_raddr got %h exp 24", rd); end
    c_bvalid = 1'b1; c_bwe = 1'b0; c_bdata = 16'hBEEF;
    #1;
    checks++;
    if (r_en !== 1'b1 || r_data !== 16'hBEEF) begin
      errors++; $display("FAIL resp_fwd got en%b d%h exp en1 dbeef", r_en, r_data);
    end
    @(negedge clk);
    c_bwe = 1'b1;
    #1;
    checks++;
    if (r_en !== 1'b0) begin errors++; $display("FAIL resp_wr_ignored got %b exp 0", r_en); end
    c_bvalid = 1'b0; c_bwe = 1'b0;
    host_write(3'd4, 32'h0);
    c_bvalid = 1'b1;
    #1;
    checks++;
    if (r_en !== 1'b1) begin errors++; $display("FAIL resp_disabled got %b exp 1", r_en); end
    @(negedge clk);
    c_bvalid = 1'b0;
  endtask

  task automatic test_backpressure;
    do_reset();
    host_write(3'd0, 32'h30);
    host_write(3'd1, 32'd3);
    c_aready = 1'b1;
    host_write(3'd4, 32'h1);
    #1;
    checks++;
    if ({c_avalid, c_awe} !== 2'b10 || c_aaddr !== 24'h30) begin
      errors++; $display("FAIL bp_first got v%b we%b a%h exp v1 we0 a30", c_avalid, c_awe, c_aaddr);
    end
    @(negedge clk);
    r_almost_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (c_avalid !== 1'b0) begin errors++; $display("FAIL bp_stall%0d got %b exp 0", i, c_avalid); end
      @(negedge clk);
    end
    r_almost_full = 1'b0;
    for (int i = 1; i < 4; i++) begin
      #1;
      checks++;
      if (c_avalid !== (i < 3) || (i < 3 && c_aaddr !== 24'h30 + 24'(i))) begin
        errors++; $display("FAIL bp_resume%0d got v%b a%h", i, c_avalid, c_aaddr);
      end
      @(negedge clk);
    end
    c_aready = 1'b0;
    host_read(3'd1, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL bp_rcount got %h exp 0", rd); end
    host_read(3'd0, rd);
    checks++;
    if (rd !== 32'h33) begin errors++; $display("FAIL bp_raddr got %h exp 33", rd); end
  endtask

  task automatic test_collision;
    host_write(3'd1, 32'd2);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (c_avalid !== 1'b1 || c_aaddr !== 24'h33) begin
        errors++; $display("FAIL col_hold%0d got v%b a%h exp v1 a33", i, c_avalid, c_aaddr);
      end
      @(negedge clk);
    end
    avalid = 1'b1; awe = 1'b1; aaddr = 3'd0; adata = 32'h40; c_aready = 1'b1;
    @(negedge clk);
    avalid = 1'b0; awe = 1'b0; c_aready = 1'b0;
    host_read(3'd0, rd);
    checks++;
    if (rd !== 32'h40) begin errors++; $display("FAIL col_raddr got %h exp 40", rd); end
    host_read(3'd1, rd);
    checks++;
    if (rd !== 32'd1) begin errors++; $display("FAIL col_rcount got %h exp 1", rd); end
  endtask

  task automatic test_priority_hold;
    do_reset();
    host_write(3'd1, 32'd5);
    host_write(3'd0, 32'h50);
    w_empty = 1'b0;
    host_write(3'd4, 32'h1);
    #1;
    checks++;
    if (c_awe !== 1'b1) begin errors++; $display("FAIL prio_wfirst got %b exp 1", c_awe); end
    host_write(3'd4, 32'h5);
    #1;
    checks++;
    if (c_awe !== 1'b1) begin errors++; $display("FAIL prio_hold_wr got %b exp 1", c_awe); end
    @(negedge clk);
    w_empty = 1'b1;
    #1;
    checks++;
    if (c_awe !== 1'b0) begin errors++; $display("FAIL prio_only_rd got %b exp 0", c_awe); end
    @(negedge clk);
    w_empty = 1'b0;
    host_write(3'd4, 32'h1);
    #1;
    checks++;
    if (c_awe !== 1'b0 || c_aaddr !== 24'h50) begin
      errors++; $display("FAIL prio_hold_rd got we%b a%h exp we0 a50", c_awe, c_aaddr);
    end
    c_aready = 1'b1;
    @(negedge clk);
    c_aready = 1'b0;
    #1;
    checks++;
    if (c_awe !== 1'b1) begin errors++; $display("FAIL prio_release got %b exp 1", c_awe); end
    rprio = 1'b1;
    host_write(3'd4, 32'hD);
    #1;
    checks++;
    if (c_awe !== 1'b1) begin errors++; $display("FAIL prio_rprio_held got %b exp 1", c_awe); end
    c_aready = 1'b1;
    @(negedge clk);
    c_aready = 1'b0;
    #1;
    checks++;
    if (c_awe !== 1'b0 || c_aaddr !== 24'h51) begin
      errors++; $display("FAIL prio_rprio_rd got we%b a%h exp we0 a51", c_awe, c_aaddr);
    end
    @(negedge clk);
    w_empty = 1'b1; rprio = 1'b0;
  endtask

  task automatic test_reset_mid_burst;
    logic [31:0] exp [8];
    exp = '{32'h0, 32'h0, 32'h0, 32'h00FFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    do_reset();
    host_write(3'd1, 32'd2);
    host_write(3'd2, 32'h10);
    host_write(3'd3, 32'h13);
    w_empty = 1'b0; c_aready = 1'b1;
    host_write(3'd4, 32'h3);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; avalid = 1'b1; awe = 1'b0; aaddr = 3'd4; c_bvalid = 1'b1; c_bwe = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({c_avalid, w_en, r_en, bvalid} !== 4'b0) begin
        errors++; $display("FAIL mid_rst%0d got %b exp 0000", i, {c_avalid, w_en, r_en, bvalid});
      end
      @(negedge clk);
    end
    rst_n = 1'b1; avalid = 1'b0; w_empty = 1'b1; c_aready = 1'b0;
    #1;
    checks++;
    if (r_en !== 1'b0) begin errors++; $display("FAIL mid_rst_stale_resp got %b exp 0", r_en); end
    c_bvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      host_read(3'(i), rd);
      checks++;
      if (rd !== exp[i]) begin errors++; $display("FAIL mid_rst_reg%0d got %h exp %h", i, rd, exp[i]); end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_ring_wrap();
    test_linear_full();
    test_round_robin();
    test_backpressure();
    test_collision();
    test_priority_hold();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
